// File: rtl/seq_div_pkg.sv
// Shared types and handshake constants for the execute-stage divider.
package seq_div_pkg;

    typedef logic [31:0] Reg_t;
    typedef logic [63:0] DoubleReg_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } DivState_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Two's complement negate when neg is set; also yields magnitudes,
    // with 0x80000000 mapping onto itself as the unsigned value 2^31.
    function automatic Reg_t fix_sign(input Reg_t x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/seq_div.sv
// Radix-2 restoring divider, one quotient bit per cycle, returning
// {remainder, quotient} with a registered ready flag for the EX stall release.
module seq_div
    import seq_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       signed_div_i,
    input  Reg_t       opdata1_i,
    input  Reg_t       opdata2_i,
    input  logic       start_i,
    input  logic       annul_i,
    output DoubleReg_t result_o,
    output logic       ready_o
);

    DivState_t  state;
    DivState_t  next_state;
    logic [5:0] count;
    Reg_t       rem;
    Reg_t       quo;
    Reg_t       dvs;
    logic       quo_neg;
    logic       rem_neg;
    DoubleReg_t result;
    logic       ready;

    logic        accept;
    logic [32:0] shifted;
    logic [32:0] diff;
    Reg_t        step_rem;
    Reg_t        step_quo;

    assign accept = (start_i == DivStart) && !annul_i;

    // The quotient register starts out holding the dividend magnitude and
    // its MSB feeds the partial remainder as quotient bits shift in below.
    always_comb begin
        shifted  = {rem, quo[31]};
        diff     = shifted - {1'b0, dvs};
        step_rem = diff[32] ? shifted[31:0] : diff[31:0];
        step_quo = {quo[30:0], ~diff[32]};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FREE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FREE: begin
                if (accept) next_state = (opdata2_i == '0) ? BYZERO : ON;
            end
            BYZERO: next_state = END;
            ON: begin
                if (annul_i)             next_state = FREE;
                else if (count == 6'd31) next_state = END;
            end
            END: begin
                if (start_i == DivStop) next_state = FREE;
            end
            default: next_state = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            result  <= '0;
            ready   <= DivResultNotReady;
        end else begin
            unique case (state)
                FREE: begin
                    result <= '0;
                    ready  <= DivResultNotReady;
                    if (accept && opdata2_i != '0) begin
                        quo     <= fix_sign(opdata1_i, signed_div_i && opdata1_i[31]);
                        dvs     <= fix_sign(opdata2_i, signed_div_i && opdata2_i[31]);
                        quo_neg <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        rem_neg <= signed_div_i && opdata1_i[31];
                        rem     <= '0;
                        count   <= '0;
                    end
                end
                BYZERO: begin
                    result <= '0;
                    ready  <= DivResultReady;
                end
                ON: begin
                    if (annul_i) begin
                        result <= '0;
                        ready  <= DivResultNotReady;
                    end else begin
                        rem   <= step_rem;
                        quo   <= step_quo;
                        count <= count + 6'd1;
                        if (count == 6'd31) begin
                            result <= {fix_sign(step_rem, rem_neg), fix_sign(step_quo, quo_neg)};
                            ready  <= DivResultReady;
                        end
                    end
                end
                END: begin
                    if (start_i == DivStop) begin
                        result <= '0;
                        ready  <= DivResultNotReady;
                    end
                end
                default: begin
                    result <= '0;
                    ready  <= DivResultNotReady;
                end
            endcase
        end
    end

    assign result_o = result;
    assign ready_o  = ready;

endmodule
